instr_encoder_loader: RTL and testbench

//  Producer side of the opcode-decode interface. Accepts symbolic instructions (mnemonic + fields),

---
 rtl/instr_encoder_loader.sv | 208 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into 32-bit words, buffers them in a small FIFO and streams them into imem.
// Optional build macro INSTR_NOP_PAD_EN appends three all-zero NOP words after each load.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [14:0]       in_imm,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  input  logic              imem_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err_invalid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_PAD   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_op_ok;
  logic              w_push;
  logic              w_fifo_rd;
  logic              w_pop;
  logic              w_pad_xfer;
  logic              w_xfer;
  logic [31:0]       w_enc;

  // Field placement for each mnemonic; FP ops reuse the R layout with funct forced to zero.
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [14:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (op)
      4'd0:    w = {7'd0,  rs, rt, rd, 4'd0, funct};
      4'd1:    w = {7'd8,  rs, rt, imm};
      4'd2:    w = {7'd35, rs, rt, imm};
      4'd3:    w = {7'd43, rs, rt, imm};
      4'd4:    w = {7'd4,  rs, rt, imm};
      4'd5:    w = {7'd2,  10'd0, imm};
      4'd6:    w = {7'd10, rs, rt, rd, 10'd0};
      4'd7:    w = {7'd11, rs, rt, rd, 10'd0};
      4'd8:    w = {7'd12, rs, rt, rd, 10'd0};
      4'd9:    w = {7'd13, rs, rt, rd, 10'd0};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign w_full     = (r_count == DEPTH_L);
  assign w_empty    = (r_count == '0);
  assign w_op_ok    = (in_op <= 4'd9);
  assign w_accept   = in_valid & in_ready;
  assign w_push     = w_accept & w_op_ok;
  assign w_fifo_rd  = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && !w_empty;
  assign w_pop      = w_fifo_rd & imem_wr_ready;
  assign w_xfer     = w_pop | w_pad_xfer;
  assign w_enc      = encode_instr(in_op, in_rs, in_rt, in_rd, in_funct, in_imm);

  assign imem_wr_addr = r_addr;
  assign err_invalid  = r_err;

`ifdef INSTR_NOP_PAD_EN
  logic [1:0] r_pad_cnt;

  assign w_pad_xfer = (r_state == S_PAD) && imem_wr_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pad_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_pad_cnt <= '0;
    end else if (w_pad_xfer) begin
      r_pad_cnt <= r_pad_cnt + 2'd1;
    end
  end
`else
  assign w_pad_xfer = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (r_accepted == r_num) w_next = S_DRAIN;
`ifdef INSTR_NOP_PAD_EN
      S_DRAIN: if (w_empty) w_next = S_PAD;
      S_PAD:   if (w_pad_xfer && r_pad_cnt == 2'd2) w_next = S_DONE;
`else
      S_DRAIN: if (w_empty) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    imem_wr_en   = 1'b0;
    imem_wr_data = '0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready     = !w_full && (r_accepted < r_num);
        imem_wr_en   = w_fifo_rd;
        imem_wr_data = w_fifo_rd ? r_mem[r_rptr] : '0;
      end
      S_DRAIN: begin
        imem_wr_en   = w_fifo_rd;
        imem_wr_data = w_fifo_rd ? r_mem[r_rptr] : '0;
      end
`ifdef INSTR_NOP_PAD_EN
      S_PAD:   imem_wr_en = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_enc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_num      <= '0;
      r_accepted <= '0;
      r_err      <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr     <= start_addr;
        r_num      <= num_instr;
        r_accepted <= '0;
        r_err      <= 1'b0;
      end else if (w_xfer) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_accept) begin
        r_accepted <= r_accepted + 1'b1;
        if (!w_op_ok) r_err <= 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized scoreboard bench for instr_encoder_loader; expected imem writes come from a field-arithmetic model.
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [14:0] imm;
  } instr_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  num_instr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [14:0] in_imm;
  logic        imem_wr_en;
  logic [7:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        imem_wr_ready;
  logic        busy, done, err_invalid;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  wr_t         sb[$];
  instr_t      prog[$];
  logic [7:0]  exp_addr;
  logic        err_exp;
  logic [31:0] first_word;
  logic        have_first;

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .imem_wr_ready(imem_wr_ready), .busy(busy), .done(done),
    .err_invalid(err_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input instr_t t);
    longint opc;
    longint w;
    case (t.op)
      4'd0: opc = 0;   4'd1: opc = 8;   4'd2: opc = 35;  4'd3: opc = 43;
      4'd4: opc = 4;   4'd5: opc = 2;   4'd6: opc = 10;  4'd7: opc = 11;
      4'd8: opc = 12;  4'd9: opc = 13;  default: opc = 0;
    endcase
    if (t.op == 4'd5)
      w = opc * 33554432 + longint'(t.imm);
    else if (t.op >= 4'd1 && t.op <= 4'd4)
      w = opc * 33554432 + longint'(t.rs) * 1048576 + longint'(t.rt) * 32768 + longint'(t.imm);
    else
      w = opc * 33554432 + longint'(t.rs) * 1048576 + longint'(t.rt) * 32768
          + longint'(t.rd) * 1024 + ((t.op == 4'd0) ? longint'(t.funct) : 0);
    return w[31:0];
  endfunction

  function automatic instr_t mk(input int op, input int rs, input int rt, input int rd,
                                input int funct, input int imm);
    instr_t t;
    t.op = 4'(op); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.funct = 6'(funct); t.imm = 15'(imm);
    return t;
  endfunction

  function automatic instr_t rand_instr(input bit allow_bad);
    instr_t t;
    t = instr_t'({$urandom, $urandom});
    if (allow_bad && ($urandom % 8 == 0)) t.op = 4'(10 + $urandom % 6);
    else t.op = 4'($urandom % 10);
    return t;
  endfunction

  task automatic accept_instr(input instr_t t);
    wr_t e;
    if (t.op <= 4'd9) begin
      e.addr = exp_addr;
      e.data = model_word(t);
      if (!have_first) begin
        first_word = e.data;
        have_first = 1'b1;
      end
      sb.push_back(e);
      exp_addr = exp_addr + 8'd1;
    end else begin
      err_exp = 1'b1;
    end
  endtask

  // mode 0: memory always ready, 1: ready held low until stall_at, 2: random ready
  task automatic send_all(input int mode, input int stall_at);
    int idx = 0;
    int cyc = 0;
    while (idx < prog.size() && cyc < 400) begin
      {in_op, in_rs, in_rt, in_rd, in_funct, in_imm} = prog[idx];
      in_valid = 1'b1;
      @(negedge clk);
      cyc++;
      if (stall_at > 0 && cyc == stall_at) begin
        chk("stall_accepted", idx, 4);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_busy", busy, 1);
        chk("stall_wr_en", imem_wr_en, 1);
        chk("stall_wr_addr", imem_wr_addr, start_addr);
        chk("stall_wr_data", imem_wr_data, first_word);
      end
      if (in_ready) begin
        accept_instr(prog[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (stall_at > 0 && cyc == stall_at) imem_wr_ready = 1'b1;
      else if (mode == 2) imem_wr_ready = 1'($urandom % 2);
    end
    in_valid = 1'b0;
    chk("accept_all", idx, prog.size());
  endtask

  task automatic start_load(input logic [7:0] saddr);
    exp_addr   = saddr;
    err_exp    = 1'b0;
    have_first = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = saddr;
    num_instr  = 8'(prog.size());
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic finish_load(input int mode);
    bit seen = 1'b0;
    wr_t e;
`ifdef INSTR_NOP_PAD_EN
    for (int p = 0; p < 3; p++) begin
      e.addr = exp_addr;
      e.data = 32'h0;
      sb.push_back(e);
      exp_addr = exp_addr + 8'd1;
    end
`endif
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      imem_wr_ready = (mode == 2) ? 1'($urandom % 2) : 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("err_invalid", err_invalid, err_exp);
    chk("writes_left", sb.size(), 0);
    chk("final_addr", imem_wr_addr, exp_addr);
    @(posedge clk); #1;
    imem_wr_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_load(input logic [7:0] saddr, input int mode, input int stall_at);
    if (mode == 1) imem_wr_ready = 1'b0;
    start_load(saddr);
    send_all(mode, stall_at);
    finish_load(mode);
  endtask

  // Write-side monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_wr_en", imem_wr_en, 1);
        chk("hold_wr_addr", imem_wr_addr, prev_addr);
        chk("hold_wr_data", imem_wr_data, prev_data);
      end
      if (imem_wr_en && imem_wr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", imem_wr_addr, 32'hDEAD_BEEF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", imem_wr_addr, e.addr);
          chk("wr_data", imem_wr_data, e.data);
        end
      end
      prev_stall = imem_wr_en && !imem_wr_ready;
      prev_addr  = imem_wr_addr;
      prev_data  = imem_wr_data;
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    reset_n = 1'b0; start = 1'b1; start_addr = 8'h00; num_instr = 8'd0;
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_funct = '0; in_imm = '0; imem_wr_ready = 1'b1;

    // reset with start held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", imem_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_invalid, 0);
    chk("rst_wr_addr", imem_wr_addr, 0);
    chk("rst_wr_data", imem_wr_data, 0);
    @(posedge clk); #1;
    start = 1'b0; reset_n = 1'b1;

    // two immediate-format instructions
    prog = '{mk(1, 1, 2, 0, 0, 5), mk(2, 3, 4, 0, 0, 15'h7FFF)};
    do_load(8'h10, 0, 0);

    // memory stalled: FIFO fills, then releases
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back(rand_instr(1'b0));
    do_load(8'h40, 1, 10);

    // address wrap, jump and FP encodings
    prog = '{mk(5, 0, 0, 0, 0, 15'h1234), mk(8, 0, 0, 7, 6'h3F, 0)};
    do_load(8'hFF, 0, 0);

    // invalid mnemonic in the middle
    prog = '{mk(0, 5, 6, 7, 6'h20, 0), mk(12, 1, 1, 1, 1, 1), mk(3, 9, 10, 0, 0, 15'h0042)};
    do_load(8'h80, 0, 0);
    chk("err_sticky", err_invalid, 1);

    // empty program; its start clears the error flag
    prog.delete();
    do_load(8'h20, 0, 0);

    // randomized loads with random memory back-pressure
    for (int r = 0; r < 8; r++) begin
      int n;
      prog.delete();
      n = 1 + int'($urandom % 7);
      for (int i = 0; i < n; i++) prog.push_back(rand_instr(1'b1));
      do_load(8'($urandom), 2, 0);
    end

    // reset during drain
    prog = '{rand_instr(1'b0), rand_instr(1'b0)};
    imem_wr_ready = 1'b0;
    start_load(8'($urandom));
    send_all(1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_wr_en", imem_wr_en, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete();
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", imem_wr_en, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    imem_wr_ready = 1'b1;

    // recovery after abort
    prog = '{rand_instr(1'b0), rand_instr(1'b0), rand_instr(1'b0)};
    do_load(8'h33, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
